// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single memory port between three requesters: the data port, the
// instruction fetch port and a debug/loader port. It serialises transactions,
// supports variable memory latency through a mem_req/mem_ack handshake, stops
// a busy stream of data/fetch traffic from starving the debug port, and
// aborts a transaction that the memory never acknowledges.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   d_req/d_we/d_addr/d_wdata       data-port request, held until d_ack
//   f_req/f_addr                    fetch request (always a read)
//   g_req/g_we/g_addr/g_wdata       debug-port request
//   d_ack/f_ack/g_ack               one-cycle completion pulse per port
//   rdata, err                      read data / timeout flag, valid with an ack
//   grant                           current owner: 0 data, 1 fetch, 2 debug, 3 none
//   busy                            high whenever the FSM is not idle
//   mem_req/mem_we/mem_addr/mem_wdata   request to the memory macro
//   mem_rdata, mem_ack              response from the memory macro
//
// All outputs are registered. A transaction takes at least three cycles:
// grant edge (IDLE->BUSY), mem_ack edge (BUSY->RESP), ack cycle (RESP->IDLE).

module mem_port_arbiter #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  input  logic          g_req,
  input  logic          g_we,
  input  logic [AW-1:0] g_addr,
  input  logic [DW-1:0] g_wdata,
  output logic          g_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [1:0]    grant,
  output logic          busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [1:0] GntData  = 2'd0;
  localparam logic [1:0] GntFetch = 2'd1;
  localparam logic [1:0] GntDebug = 2'd2;
  localparam logic [1:0] GntNone  = 2'd3;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);
  localparam logic [7:0] Timeout = 8'(TIMEOUT);

  state_e          state;
  logic [3:0]      wait_cnt;   // arbitrations lost by a pending debug request
  logic [7:0]      tmo_cnt;    // BUSY cycles spent on the current transaction
  logic [7:0]      tmo_next;

  // Arbitration result for the current IDLE cycle
  logic            sel_valid;
  logic [1:0]      sel_port;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  assign tmo_next = tmo_cnt + 8'd1;

  always_comb begin
    sel_valid = d_req | f_req | g_req;
    sel_port  = GntNone;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    // A debug request that has waited long enough jumps the fixed priority.
    if (g_req && (wait_cnt == MaxWait)) begin
      sel_port  = GntDebug;
      sel_we    = g_we;
      sel_addr  = g_addr;
      sel_wdata = g_wdata;
    end else if (d_req) begin
      sel_port  = GntData;
      sel_we    = d_we;
      sel_addr  = d_addr;
      sel_wdata = d_wdata;
    end else if (f_req) begin
      sel_port  = GntFetch;
      sel_addr  = f_addr;
    end else if (g_req) begin
      sel_port  = GntDebug;
      sel_we    = g_we;
      sel_addr  = g_addr;
      sel_wdata = g_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      wait_cnt  <= '0;
      tmo_cnt   <= '0;
      d_ack     <= 1'b0;
      f_ack     <= 1'b0;
      g_ack     <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      grant     <= GntNone;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (sel_valid) begin
            mem_req   <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            grant     <= sel_port;
            busy      <= 1'b1;
            tmo_cnt   <= '0;
            state     <= StBusy;
            if (sel_port == GntDebug) begin
              wait_cnt <= '0;
            end else if (g_req && (wait_cnt != MaxWait)) begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
        end

        StBusy: begin
          tmo_cnt <= tmo_next;
          // mem_ack wins over a timeout landing in the same cycle
          if (mem_ack || (tmo_next == Timeout)) begin
            mem_req <= 1'b0;
            rdata   <= mem_ack ? mem_rdata : '0;
            err     <= ~mem_ack;
            d_ack   <= (grant == GntData);
            f_ack   <= (grant == GntFetch);
            g_ack   <= (grant == GntDebug);
            state   <= StResp;
          end
        end

        StResp: begin
          d_ack <= 1'b0;
          f_ack <= 1'b0;
          g_ack <= 1'b0;
          err   <= 1'b0;
          grant <= GntNone;
          busy  <= 1'b0;
          state <= StIdle;
        end

        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. The bench owns the three
// requesters and the memory, so every expected value comes from a
// transaction-level model: who should win each arbitration, which latency the
// memory was given, and therefore when and how the transaction must finish.

module tb_mem_port_arbiter;

  localparam int AW       = 16;
  localparam int DW       = 16;
  localparam int MAX_WAIT = 4;
  localparam int TIMEOUT  = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          d_req, d_we, f_req, g_req, g_we;
  logic [AW-1:0] d_addr, f_addr, g_addr;
  logic [DW-1:0] d_wdata, g_wdata;
  logic          d_ack, f_ack, g_ack, err, busy;
  logic [DW-1:0] rdata;
  logic [1:0]    grant;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  int dbg_wait = 0;   // model: arbitrations lost by the pending debug request

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata), .g_ack(g_ack),
    .rdata(rdata), .err(err), .grant(grant), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic idle_check(input string tag);
    check_eq({tag, "_grant"}, grant, 3);
    check_eq({tag, "_memreq"}, mem_req, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_acks"}, {g_ack, f_ack, d_ack}, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  // Ports other than the owner may change their fields freely while waiting.
  task automatic jitter(input int owner);
    if (owner != 0) begin d_addr = AW'($urandom); d_wdata = DW'($urandom); d_we = 1'($urandom); end
    if (owner != 1) f_addr = AW'($urandom);
    if (owner != 2) begin g_addr = AW'($urandom); g_wdata = DW'($urandom); g_we = 1'($urandom); end
  endtask

  task automatic new_reqs();
    if (!d_req && ($urandom_range(0, 9) < 6)) begin
      d_req = 1'b1; d_we = 1'($urandom); d_addr = AW'($urandom); d_wdata = DW'($urandom);
    end
    if (!f_req && ($urandom_range(0, 9) < 6)) begin
      f_req = 1'b1; f_addr = AW'($urandom);
    end
    if (!g_req && ($urandom_range(0, 9) < 2)) begin
      g_req = 1'b1; g_we = 1'($urandom); g_addr = AW'($urandom); g_wdata = DW'($urandom);
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 11);
    if (r == 0) return $urandom_range(TIMEOUT + 1, TIMEOUT + 3);
    if (r == 1) return TIMEOUT;
    return $urandom_range(1, 6);
  endfunction

  // Called between edges while the DUT is idle and at least one req is high.
  // n is the cycle (1 = first cycle after the grant) in which memory acks.
  task automatic run_txn(input int n, input logic [DW-1:0] rd);
    int            w, last;
    logic [AW-1:0] ea;
    logic          ewe, eerr;
    logic [DW-1:0] ewd, erd;
    if (g_req && dbg_wait == MAX_WAIT) w = 2;
    else if (d_req) w = 0;
    else if (f_req) w = 1;
    else w = 2;
    case (w)
      0:       begin ea = d_addr; ewe = d_we; ewd = d_wdata; end
      1:       begin ea = f_addr; ewe = 1'b0; ewd = '0; end
      default: begin ea = g_addr; ewe = g_we; ewd = g_wdata; end
    endcase
    @(posedge clk); #1;
    check_eq("grant", grant, w);
    check_eq("mem_req_on", mem_req, 1);
    check_eq("mem_addr", mem_addr, ea);
    check_eq("mem_we", mem_we, ewe);
    if (w != 1) check_eq("mem_wdata", mem_wdata, ewd);
    check_eq("busy", busy, 1);
    if (w == 2) dbg_wait = 0;
    else if (g_req && dbg_wait < MAX_WAIT) dbg_wait++;

    last = (n <= TIMEOUT) ? n : TIMEOUT;
    eerr = (n > TIMEOUT);
    erd  = eerr ? '0 : rd;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      mem_ack   = (k == n);
      mem_rdata = (k == n) ? rd : DW'($urandom);
      jitter(w);
      @(posedge clk); #1;
      if (k < last) begin
        check_eq("hold_req", mem_req, 1);
        check_eq("hold_addr", mem_addr, ea);
        if (w != 1) check_eq("hold_wdata", mem_wdata, ewd);
        check_eq("no_early_ack", {g_ack, f_ack, d_ack}, 0);
      end
    end
    check_eq("ack_onehot", {g_ack, f_ack, d_ack}, 32'(1 << w));
    check_eq("rdata", rdata, erd);
    check_eq("err", err, eerr);
    check_eq("mem_req_off", mem_req, 0);
    check_eq("grant_resp", grant, w);
    @(negedge clk);
    mem_ack = 1'b0;
    case (w)
      0:       d_req = 1'b0;
      1:       f_req = 1'b0;
      default: g_req = 1'b0;
    endcase
    @(posedge clk); #1;
    idle_check("after_resp");
  endtask

  initial begin
    rst_n = 1'b0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    f_req = 0; f_addr = '0;
    g_req = 0; g_we = 0; g_addr = '0; g_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    idle_check("reset");
    check_eq("reset_rdata", rdata, 0);
    check_eq("reset_addr", mem_addr, 0);
    @(negedge clk) rst_n = 1'b1;

    // Single fetch with a one-cycle memory
    @(negedge clk);
    f_req = 1'b1; f_addr = 16'h0040;
    run_txn(1, 16'h2A05);

    // Simultaneous data write and fetch; data times out, fetch then 5-cycle latency
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
    f_req = 1'b1; f_addr = 16'h0044;
    run_txn(TIMEOUT + 2, 16'h1234);
    run_txn(5, 16'h5A5A);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      new_reqs();
      if (d_req || f_req || g_req) begin
        run_txn(pick_lat(), DW'($urandom));
      end else begin
        mem_ack   = 1'($urandom);   // must be ignored while idle
        mem_rdata = DW'($urandom);
        @(posedge clk); #1;
        idle_check("idle");
      end
    end

    // Reset in the middle of a transaction
    @(negedge clk);
    mem_ack = 1'b0;
    f_req = 1'b0; g_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_grant", grant, 3);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    d_req = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b0; dbg_wait = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      idle_check("post_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
